// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, 2-entry {pc, instr} queue, valid/ready
// delivery to decode. Optional back-pressure counter under FETCH_STALL_CNT_EN.
module fetch_unit #(
    parameter int unsigned   N        = 64,
    parameter int unsigned   IW       = 32,
    parameter logic [N-1:0]  RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    output logic [N-1:0]  imem_addr,
    input  logic [IW-1:0] imem_rdata,
    input  logic          redirect_valid,
    input  logic [N-1:0]  redirect_pc,
    output logic          if_valid,
    input  logic          if_ready,
    output logic [N-1:0]  if_pc,
    output logic [IW-1:0] if_instr,
    output logic [31:0]   stall_cnt
);

    typedef struct packed {
        logic [N-1:0]  pc;
        logic [IW-1:0] instr;
    } entry_t;

    logic [N-1:0] pc_q, pc_d;
    logic [1:0]   count_q, count_d;
    entry_t       head_q, head_d;
    entry_t       tail_q, tail_d;
    entry_t       new_ent;
    logic         pop, fetch_en, push;

    // Low address bits of a redirect target are discarded by design.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign imem_addr = pc_q;
    assign if_valid  = (count_q != 2'd0);
    assign if_pc     = head_q.pc;
    assign if_instr  = head_q.instr;

    always_comb begin
        pop      = if_valid && if_ready;
        fetch_en = (count_q < 2'd2) || pop;
        push     = fetch_en && !redirect_valid;
        new_ent  = '{pc: pc_q, instr: imem_rdata};
        pc_d     = pc_q;
        count_d  = count_q;
        head_d   = head_q;
        tail_d   = tail_q;
        if (redirect_valid) begin
            pc_d    = {redirect_pc[N-1:2], 2'b00};
            count_d = 2'd0;
        end else begin
            if (push) begin
                pc_d = pc_q + N'(4);
            end
            // Head is always slot 0; a pop shifts the tail forward before any push lands.
            unique case ({push, pop})
                2'b11: begin
                    if (count_q == 2'd2) begin
                        head_d = tail_q;
                        tail_d = new_ent;
                    end else begin
                        head_d = new_ent;
                    end
                end
                2'b10: begin
                    if (count_q == 2'd0) head_d = new_ent;
                    else                 tail_d = new_ent;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) head_d = tail_q;
                    count_d = count_q - 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if (if_valid && !if_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] stall_cnt;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    fetch_unit #(.N(64), .IW(32), .RESET_PC(64'h0)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .stall_cnt      (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = word_at(imem_addr);

`ifdef FETCH_STALL_CNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    // Reference model: FIFO of fetched pairs, next PC and stall count.
    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;
    ent_t        mq[$];
    logic [63:0] m_pc;
    logic [31:0] m_stall;

    task automatic model_step();
        bit valid;
        if (reset) begin
            mq.delete();
            m_pc    = 64'h0;
            m_stall = 32'h0;
            return;
        end
        valid = (mq.size() > 0);
        if (STALL_EN && valid && !if_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (valid && if_ready) void'(mq.pop_front());
        if (redirect_valid) begin
            mq.delete();
            m_pc = redirect_pc & ~64'h3;
        end else if (mq.size() < 2) begin
            mq.push_back('{pc: m_pc, instr: word_at(m_pc)});
            m_pc = m_pc + 64'd4;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b1;
        tick(); tick();
        n_vec++; if (imem_addr !== 64'h0) begin n_err++; $display("FAIL rst_addr: got %h expected %h", imem_addr, 64'h0); end
        n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", if_valid); end
        n_vec++; if (if_pc !== 64'h0) begin n_err++; $display("FAIL rst_pc: got %h expected 0", if_pc); end
        n_vec++; if (if_instr !== 32'h0) begin n_err++; $display("FAIL rst_instr: got %h expected 0", if_instr); end
        n_vec++; if (stall_cnt !== 32'h0) begin n_err++; $display("FAIL rst_stall: got %0d expected 0", stall_cnt); end
        reset = 1'b0;
        tick();
        n_vec++; if (if_valid !== 1'b1 || if_pc !== 64'h0 || if_instr !== word_at(64'h0))
            begin n_err++; $display("FAIL first_fetch: got v=%b pc=%h i=%h expected v=1 pc=0 i=%h", if_valid, if_pc, if_instr, word_at(64'h0)); end
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 6; i++) begin
            tick();
            n_vec++; if (if_valid !== 1'b1 || if_pc !== 64'(4 * i) || if_instr !== word_at(64'(4 * i)))
                begin n_err++; $display("FAIL stream[%0d]: got v=%b pc=%h expected pc=%h", i, if_valid, if_pc, 64'(4 * i)); end
        end
    endtask

    task automatic test_back_pressure();
        logic [63:0] p;
        p = 64'd24;
        if_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_vec++; if (if_valid !== 1'b1 || if_pc !== p || if_instr !== word_at(p))
                begin n_err++; $display("FAIL bp_hold[%0d]: got v=%b pc=%h expected pc=%h", k, if_valid, if_pc, p); end
            n_vec++; if (imem_addr !== p + 64'd8)
                begin n_err++; $display("FAIL bp_addr[%0d]: got %h expected %h", k, imem_addr, p + 64'd8); end
        end
        n_vec++; if (stall_cnt !== (STALL_EN ? 32'd5 : 32'd0))
            begin n_err++; $display("FAIL bp_stall: got %0d expected %0d", stall_cnt, STALL_EN ? 5 : 0); end
        if_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_vec++; if (if_valid !== 1'b1 || if_pc !== p + 64'(4 * k))
                begin n_err++; $display("FAIL bp_resume[%0d]: got %h expected %h", k, if_pc, p + 64'(4 * k)); end
        end
        n_vec++; if (stall_cnt !== (STALL_EN ? 32'd5 : 32'd0))
            begin n_err++; $display("FAIL bp_stall_keep: got %0d expected %0d", stall_cnt, STALL_EN ? 5 : 0); end
    endtask

    task automatic test_redirect();
        if_ready = 1'b0;
        tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 64'h103;
        tick();
        redirect_valid = 1'b0;
        n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL redir_flush: got %b expected 0", if_valid); end
        n_vec++; if (imem_addr !== 64'h100) begin n_err++; $display("FAIL redir_addr: got %h expected %h", imem_addr, 64'h100); end
        if_ready = 1'b1;
        tick();
        n_vec++; if (if_valid !== 1'b1 || if_pc !== 64'h100 || if_instr !== word_at(64'h100))
            begin n_err++; $display("FAIL redir_t2: got v=%b pc=%h expected pc=%h", if_valid, if_pc, 64'h100); end
        tick();
        n_vec++; if (if_pc !== 64'h104) begin n_err++; $display("FAIL redir_t3: got %h expected %h", if_pc, 64'h104); end
    endtask

    task automatic test_simultaneous();
        redirect_valid = 1'b1; redirect_pc = 64'h200; if_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        n_vec++; if (if_valid !== 1'b0 || imem_addr !== 64'h200)
            begin n_err++; $display("FAIL redir_pop: got v=%b addr=%h expected v=0 addr=%h", if_valid, imem_addr, 64'h200); end
        tick();
        n_vec++; if (if_valid !== 1'b1 || if_pc !== 64'h200)
            begin n_err++; $display("FAIL redir_pop_next: got %h expected %h", if_pc, 64'h200); end
        reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h300;
        tick();
        reset = 1'b0; redirect_valid = 1'b0;
        n_vec++; if (if_valid !== 1'b0 || imem_addr !== 64'h0)
            begin n_err++; $display("FAIL rst_redir: got v=%b addr=%h expected v=0 addr=0", if_valid, imem_addr); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (if_valid !== 1'b1 || if_pc !== 64'(4 * i) || imem_addr !== 64'(4 * i + 4))
                begin n_err++; $display("FAIL rst_redir_seq[%0d]: got pc=%h addr=%h expected pc=%h", i, if_pc, imem_addr, 64'(4 * i)); end
        end
    endtask

    task automatic test_wrap();
        logic [63:0] exp_seq [3];
        exp_seq = '{64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h4};
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC; if_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (if_valid !== 1'b1 || if_pc !== exp_seq[i] || if_instr !== word_at(exp_seq[i]))
                begin n_err++; $display("FAIL wrap[%0d]: got %h expected %h", i, if_pc, exp_seq[i]); end
        end
    endtask

    task automatic test_random();
        reset = 1'b1; redirect_valid = 1'b0;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 600; c++) begin
            reset          = ($urandom_range(99) == 0);
            redirect_valid = ($urandom_range(99) < 8);
            redirect_pc    = {$urandom(), $urandom()};
            if_ready       = ($urandom_range(99) < 65);
            tick();
            n_vec++; if (imem_addr !== m_pc)
                begin n_err++; $display("FAIL rnd_addr[%0d]: got %h expected %h", c, imem_addr, m_pc); end
            n_vec++; if (if_valid !== (mq.size() > 0))
                begin n_err++; $display("FAIL rnd_valid[%0d]: got %b expected %b", c, if_valid, mq.size() > 0); end
            if (mq.size() > 0) begin
                n_vec++; if (if_pc !== mq[0].pc || if_instr !== mq[0].instr)
                    begin n_err++; $display("FAIL rnd_head[%0d]: got %h/%h expected %h/%h", c, if_pc, if_instr, mq[0].pc, mq[0].instr); end
            end
            n_vec++; if (stall_cnt !== m_stall)
                begin n_err++; $display("FAIL rnd_stall[%0d]: got %0d expected %0d", c, stall_cnt, m_stall); end
        end
    endtask

    initial begin
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b1;
        m_pc = '0; m_stall = '0;
        test_reset();
        test_stream();
        test_back_pressure();
        test_redirect();
        test_simultaneous();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
